// File: rtl/dfe_cfg_sequencer.sv
// Register-mapped configuration controller and apply/stop sequencer for the DFE chain.
// Shadow registers are written over an APB-subset port and committed atomically between a drain and a warm-up.
module dfe_cfg_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DRAIN_CYCLES  = 64,
    parameter int WARMUP_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [3:0]              PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic [5*DATA_WIDTH-1:0] filter_coeff_notch_1,
    output logic [5*DATA_WIDTH-1:0] filter_coeff_notch_2,
    output logic [2:0]              CIC_Decimation_Factor,
    output logic                    FD_EN,
    output logic                    CLKDIV_EN,
    output logic                    NOTCH_EN_1,
    output logic                    NOTCH_EN_2,
    output logic                    CIC_EN,
    output logic                    FD_bypass,
    output logic                    NOTCH_bypass_1,
    output logic                    NOTCH_bypass_2,
    output logic                    CIC_bypass,
    output logic                    out_mute
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_LOAD   = 3'd2,
        S_ENABLE = 3'd3,
        S_WARMUP = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    localparam int MAX_CYCLES = (DRAIN_CYCLES > WARMUP_CYCLES) ? DRAIN_CYCLES : WARMUP_CYCLES;
    // The shared counter also steps through the five enable stages, so it never drops below 3 bits.
    localparam int CNT_BASE = $clog2(MAX_CYCLES) + 1;
    localparam int CNT_W    = (CNT_BASE < 3) ? 3 : CNT_BASE;
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENABLE_LAST = CNT_W'(4);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                stopping, stopping_next;
    logic                apply_pending, pending_next;
    logic                cfg_err, err_next;
    logic                commit;

    logic [DATA_WIDTH-1:0] shadow_coeff [10];
    logic [DATA_WIDTH-1:0] active_coeff [10];
    logic [3:0]            shadow_bypass, active_bypass;
    logic [2:0]            shadow_k, active_k;

    logic       wr_en, cmd_wr, cmd_apply, cmd_stop, cmd_clr, k_bad, busy, pending_now;
    logic [4:0] stage_en;

    assign PREADY    = !(PSEL && (PADDR <= 4'd10) && (state == S_LOAD));
    assign wr_en     = PSEL && PENABLE && PWRITE && PREADY;
    assign cmd_wr    = wr_en && (PADDR == 4'd11);
    assign cmd_apply = cmd_wr && PWDATA[0];
    assign cmd_stop  = cmd_wr && PWDATA[1];
    assign cmd_clr   = cmd_wr && PWDATA[2];
    assign k_bad     = shadow_k > 3'd4;
    assign busy      = (state != S_IDLE) && (state != S_RUN);
    assign pending_now = apply_pending || cmd_apply;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        stopping_next = stopping;
        pending_next  = apply_pending;
        err_next      = cfg_err;
        commit        = 1'b0;
        if (cmd_clr) err_next = 1'b0;
        if (cmd_stop) begin
            state_next    = S_DRAIN;
            cnt_next      = '0;
            stopping_next = 1'b1;
            pending_next  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    if (cmd_apply) begin
                        if (k_bad) begin
                            err_next = 1'b1;
                        end else begin
                            state_next    = S_DRAIN;
                            cnt_next      = '0;
                            stopping_next = 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cmd_apply) pending_next = 1'b1;
                    if (cnt == DRAIN_LAST) begin
                        state_next = stopping ? S_IDLE : S_LOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    if (cmd_apply) pending_next = 1'b1;
                    state_next = S_ENABLE;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end
                S_ENABLE: begin
                    if (cmd_apply) pending_next = 1'b1;
                    if (cnt == ENABLE_LAST) begin
                        state_next = S_WARMUP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (cmd_apply) pending_next = 1'b1;
                    if (cnt == WARMUP_LAST) begin
                        cnt_next   = '0;
                        state_next = S_RUN;
                        // A queued apply skips RUN entirely so the output never unmutes in between.
                        if (pending_now) begin
                            pending_next = 1'b0;
                            if (k_bad) begin
                                err_next = 1'b1;
                            end else begin
                                state_next    = S_DRAIN;
                                stopping_next = 1'b0;
                            end
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            stopping      <= 1'b0;
            apply_pending <= 1'b0;
            cfg_err       <= 1'b0;
            // NOTE: the coefficient arrays are reset because their reset value is architecturally visible.
            for (int i = 0; i < 10; i++) begin
                shadow_coeff[i] <= '0;
                active_coeff[i] <= '0;
            end
            shadow_bypass <= 4'hF;
            active_bypass <= 4'hF;
            shadow_k      <= 3'd0;
            active_k      <= 3'd0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            stopping      <= stopping_next;
            apply_pending <= pending_next;
            cfg_err       <= err_next;
            for (int i = 0; i < 10; i++) begin
                if (wr_en && (PADDR == 4'(i))) shadow_coeff[i] <= PWDATA;
            end
            if (wr_en && (PADDR == 4'd10)) begin
                shadow_bypass <= PWDATA[3:0];
                shadow_k      <= PWDATA[6:4];
            end
            if (commit) begin
                active_coeff  <= shadow_coeff;
                active_bypass <= shadow_bypass;
                active_k      <= shadow_k;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            for (int i = 0; i < 10; i++) begin
                if (PADDR == 4'(i)) PRDATA = shadow_coeff[i];
            end
            if (PADDR == 4'd10) PRDATA = DATA_WIDTH'({shadow_k, shadow_bypass});
            if (PADDR == 4'd12) PRDATA = DATA_WIDTH'({apply_pending, cfg_err, state, busy});
        end
    end

    always_comb begin
        stage_en = '0;
        out_mute = 1'b1;
        case (state)
            S_ENABLE: begin
                for (int i = 0; i < 5; i++) stage_en[i] = (cnt >= CNT_W'(i));
            end
            S_WARMUP: stage_en = '1;
            S_RUN: begin
                stage_en = '1;
                out_mute = 1'b0;
            end
            default: ;
        endcase
    end

    assign FD_EN      = stage_en[0];
    assign CLKDIV_EN  = stage_en[1];
    assign NOTCH_EN_1 = stage_en[2];
    assign NOTCH_EN_2 = stage_en[3];
    assign CIC_EN     = stage_en[4];

    assign filter_coeff_notch_1 = {active_coeff[0], active_coeff[1], active_coeff[2],
                                   active_coeff[3], active_coeff[4]};
    assign filter_coeff_notch_2 = {active_coeff[5], active_coeff[6], active_coeff[7],
                                   active_coeff[8], active_coeff[9]};
    assign CIC_Decimation_Factor = active_k;
    assign FD_bypass      = active_bypass[0];
    assign NOTCH_bypass_1 = active_bypass[1];
    assign NOTCH_bypass_2 = active_bypass[2];
    assign CIC_bypass     = active_bypass[3];

endmodule

// File: tb/tb_dfe_cfg_sequencer.sv
// Directed self-checking bench for dfe_cfg_sequencer with DRAIN_CYCLES=4, WARMUP_CYCLES=8.
// Expected values are hand-derived from the edge-0 timing of the apply sequence.
module tb_dfe_cfg_sequencer;

    localparam int DW = 16;
    localparam logic [79:0] N1_VAL = 80'h4000_678E_4000_6473_3C38;
    localparam logic [79:0] N2_VAL = 80'h0101_0202_0303_0404_0505;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [3:0]    PADDR = '0;
    logic [DW-1:0] PWDATA = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic [79:0]   coeff_1, coeff_2;
    logic [2:0]    k_out;
    logic          FD_EN, CLKDIV_EN, NOTCH_EN_1, NOTCH_EN_2, CIC_EN;
    logic          FD_bypass, NOTCH_bypass_1, NOTCH_bypass_2, CIC_bypass;
    logic          out_mute;

    logic [4:0] en_vec;
    logic [3:0] byp_vec;
    assign en_vec  = {CIC_EN, NOTCH_EN_2, NOTCH_EN_1, CLKDIV_EN, FD_EN};
    assign byp_vec = {CIC_bypass, NOTCH_bypass_2, NOTCH_bypass_1, FD_bypass};

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [DW-1:0] rd;

    dfe_cfg_sequencer #(.DATA_WIDTH(DW), .DRAIN_CYCLES(4), .WARMUP_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .filter_coeff_notch_1(coeff_1), .filter_coeff_notch_2(coeff_2),
        .CIC_Decimation_Factor(k_out),
        .FD_EN(FD_EN), .CLKDIV_EN(CLKDIV_EN), .NOTCH_EN_1(NOTCH_EN_1),
        .NOTCH_EN_2(NOTCH_EN_2), .CIC_EN(CIC_EN),
        .FD_bypass(FD_bypass), .NOTCH_bypass_1(NOTCH_bypass_1),
        .NOTCH_bypass_2(NOTCH_bypass_2), .CIC_bypass(CIC_bypass),
        .out_mute(out_mute)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns 1ns after the requested edge count.
    task automatic wait_edge(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Returns 1ns after the commit edge; cyc then indexes that edge.
    task automatic apb_write(input logic [3:0] addr, input logic [DW-1:0] data);
        int n;
        @(negedge CLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
        @(negedge CLK);
        PENABLE = 1'b1;
        n = 0;
        while (!PREADY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        compared++;
        if (!PREADY) begin
            mismatched++;
            $display("FAIL apb_write_ready addr=%0d: PREADY got %b want 1", addr, PREADY);
        end
        @(posedge CLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [DW-1:0] data);
        @(negedge CLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
        @(negedge CLK);
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        @(posedge CLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        compared++;
        if (en_vec !== 5'b0 || out_mute !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_outputs: en=%b mute=%b want en=00000 mute=1", en_vec, out_mute);
        end
        compared++;
        if (byp_vec !== 4'hF || k_out !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_bypass_k: byp=%h k=%0d want F/0", byp_vec, k_out);
        end
        compared++;
        if (coeff_1 !== 80'h0 || coeff_2 !== 80'h0) begin
            mismatched++;
            $display("FAIL reset_coeff: n1=%h n2=%h want 0", coeff_1, coeff_2);
        end
        @(negedge CLK);
        RST = 1'b1;
        compared++;
        if (PRDATA !== 16'h0 || PREADY !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_bus: PRDATA=%h PREADY=%b want 0000/1", PRDATA, PREADY);
        end
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_status: got %h want 0000", rd);
        end
    endtask

    task automatic test_apply;
        int e0;
        logic [4:0]  exp_en;
        logic [79:0] exp_c;
        logic [6:0]  exp_cfg;
        apb_write(4'd0, 16'h4000);
        apb_write(4'd1, 16'h678E);
        apb_write(4'd2, 16'h4000);
        apb_write(4'd3, 16'h6473);
        apb_write(4'd4, 16'h3C38);
        apb_write(4'd10, 16'h0020);
        apb_write(4'd11, 16'h0001);
        e0 = cyc;
        for (int e = 0; e <= 20; e++) begin
            wait_edge(e0 + e);
            if (e >= 10)     exp_en = 5'h1F;
            else if (e >= 5) exp_en = 5'h1F >> (9 - e);
            else             exp_en = 5'h00;
            exp_c   = (e >= 5) ? N1_VAL : 80'h0;
            exp_cfg = (e >= 5) ? 7'b010_0000 : 7'b000_1111;
            compared++;
            if (en_vec !== exp_en || out_mute !== (e < 18)) begin
                mismatched++;
                $display("FAIL apply_seq edge %0d: en=%b mute=%b want en=%b mute=%b",
                         e, en_vec, out_mute, exp_en, (e < 18));
            end
            compared++;
            if (coeff_1 !== exp_c || {k_out, byp_vec} !== exp_cfg || coeff_2 !== 80'h0) begin
                mismatched++;
                $display("FAIL apply_active edge %0d: n1=%h k/byp=%b want n1=%h k/byp=%b",
                         e, coeff_1, {k_out, byp_vec}, exp_c, exp_cfg);
            end
        end
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h000A) begin
            mismatched++;
            $display("FAIL run_status: got %h want 000A", rd);
        end
    endtask

    task automatic test_cfg_err;
        apb_write(4'd10, 16'h0060);
        apb_write(4'd11, 16'h0001);
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h001A) begin
            mismatched++;
            $display("FAIL cfg_err_status: got %h want 001A", rd);
        end
        compared++;
        if (k_out !== 3'd2 || out_mute !== 1'b0 || en_vec !== 5'h1F) begin
            mismatched++;
            $display("FAIL cfg_err_active: k=%0d mute=%b en=%b want 2/0/11111", k_out, out_mute, en_vec);
        end
        apb_write(4'd11, 16'h0004);
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h000A) begin
            mismatched++;
            $display("FAIL cfg_err_clear: got %h want 000A", rd);
        end
        apb_write(4'd10, 16'h0020);
    endtask

    task automatic test_pending;
        int e0;
        apb_write(4'd5, 16'h0101);
        apb_write(4'd6, 16'h0202);
        apb_write(4'd7, 16'h0303);
        apb_write(4'd8, 16'h0404);
        apb_write(4'd9, 16'h0505);
        apb_write(4'd11, 16'h0001);
        e0 = cyc;
        wait_edge(e0 + 4);
        compared++;
        if (coeff_2 !== 80'h0) begin
            mismatched++;
            $display("FAIL n2_before_commit: got %h want 0", coeff_2);
        end
        wait_edge(e0 + 5);
        compared++;
        if (coeff_2 !== N2_VAL || coeff_1 !== N1_VAL) begin
            mismatched++;
            $display("FAIL n2_commit: n2=%h n1=%h want %h %h", coeff_2, coeff_1, N2_VAL, N1_VAL);
        end
        wait_edge(e0 + 11);
        apb_write(4'd11, 16'h0001);
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h0029) begin
            mismatched++;
            $display("FAIL pending_status: got %h want 0029", rd);
        end
        wait_edge(e0 + 17);
        compared++;
        if (en_vec !== 5'h1F || out_mute !== 1'b1) begin
            mismatched++;
            $display("FAIL pending_warmup: en=%b mute=%b want 11111/1", en_vec, out_mute);
        end
        wait_edge(e0 + 18);
        compared++;
        if (en_vec !== 5'h00 || out_mute !== 1'b1) begin
            mismatched++;
            $display("FAIL pending_redrain: en=%b mute=%b want 00000/1", en_vec, out_mute);
        end
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h0003) begin
            mismatched++;
            $display("FAIL pending_cleared: got %h want 0003", rd);
        end
        wait_edge(e0 + 36);
        compared++;
        if (out_mute !== 1'b0) begin
            mismatched++;
            $display("FAIL pending_rerun: mute=%b want 0", out_mute);
        end
    endtask

    task automatic test_load_write;
        int e0;
        apb_write(4'd11, 16'h0001);
        e0 = cyc;
        wait_edge(e0 + 3);
        @(negedge CLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 4'd3; PWDATA = 16'hBEEF; PENABLE = 1'b0;
        wait_edge(e0 + 4);
        compared++;
        if (PREADY !== 1'b0) begin
            mismatched++;
            $display("FAIL load_pready_low: got %b want 0", PREADY);
        end
        @(negedge CLK);
        PENABLE = 1'b1;
        wait_edge(e0 + 5);
        compared++;
        if (PREADY !== 1'b1) begin
            mismatched++;
            $display("FAIL load_pready_high: got %b want 1", PREADY);
        end
        wait_edge(e0 + 6);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        compared++;
        if (coeff_1 !== N1_VAL) begin
            mismatched++;
            $display("FAIL load_active_untouched: got %h want %h", coeff_1, N1_VAL);
        end
        apb_read(4'd3, rd);
        compared++;
        if (rd !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL load_shadow_write: got %h want BEEF", rd);
        end
        wait_edge(e0 + 18);
        compared++;
        if (out_mute !== 1'b0 || coeff_1 !== N1_VAL) begin
            mismatched++;
            $display("FAIL load_run: mute=%b n1=%h want 0 %h", out_mute, coeff_1, N1_VAL);
        end
    endtask

    task automatic test_stop;
        int e0, s;
        apb_write(4'd11, 16'h0001);
        e0 = cyc;
        wait_edge(e0 + 5);
        apb_write(4'd11, 16'h0002);
        s = cyc;
        compared++;
        if (en_vec !== 5'h00 || out_mute !== 1'b1) begin
            mismatched++;
            $display("FAIL stop_enables: en=%b mute=%b want 00000/1", en_vec, out_mute);
        end
        compared++;
        if (coeff_1[31:16] !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL stop_committed_a1: got %h want BEEF", coeff_1[31:16]);
        end
        wait_edge(s + 2);
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h0003) begin
            mismatched++;
            $display("FAIL stop_draining: got %h want 0003", rd);
        end
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h0000) begin
            mismatched++;
            $display("FAIL stop_idle: got %h want 0000", rd);
        end
    endtask

    task automatic test_reset_mid;
        int e0;
        apb_write(4'd11, 16'h0001);
        e0 = cyc;
        wait_edge(e0 + 12);
        compared++;
        if (en_vec !== 5'h1F || out_mute !== 1'b1) begin
            mismatched++;
            $display("FAIL warmup_before_reset: en=%b mute=%b want 11111/1", en_vec, out_mute);
        end
        @(negedge CLK);
        RST = 1'b0;
        wait_edge(e0 + 13);
        compared++;
        if (en_vec !== 5'h00 || out_mute !== 1'b1 || coeff_1 !== 80'h0 || coeff_2 !== 80'h0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: en=%b mute=%b n1=%h n2=%h", en_vec, out_mute, coeff_1, coeff_2);
        end
        compared++;
        if (byp_vec !== 4'hF || k_out !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_mid_cfg: byp=%h k=%0d want F/0", byp_vec, k_out);
        end
        @(negedge CLK);
        RST = 1'b1;
        apb_read(4'd12, rd);
        compared++;
        if (rd !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_mid_status: got %h want 0000", rd);
        end
        apb_read(4'd0, rd);
        compared++;
        if (rd !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_mid_shadow: got %h want 0000", rd);
        end
    endtask

    initial begin
        test_reset;
        test_apply;
        test_cfg_err;
        test_pending;
        test_load_write;
        test_stop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
